// File: rtl/relu_backward_pkg.sv
// Fixed-point Q8.8 types and the saturating multiply shared by relu/relu_backward.
package fixedpoint;

    typedef logic signed [15:0] fixed_point_t;

    localparam int           FRAC_BITS = 8;
    localparam fixed_point_t FP_MAX    = 16'sh7FFF;
    localparam fixed_point_t FP_MIN    = 16'sh8000;

    // Q8.8 x Q8.8 -> Q16.16, arithmetic shift back to Q8.8, clamp to 16 bits.
    function automatic fixed_point_t multiply(input fixed_point_t a, input fixed_point_t b);
        logic signed [31:0] prod;
        logic signed [23:0] shifted;
        prod    = a * b;
        shifted = prod[31:FRAC_BITS];
        if (shifted > 24'sd32767)
            return FP_MAX;
        else if (shifted < -24'sd32768)
            return FP_MIN;
        else
            return fixed_point_t'(shifted[15:0]);
    endfunction

endpackage

// File: rtl/relu_backward_if.sv
// Forward capture, upstream gradient and downstream gradient streams.
interface relu_backward_if;
    import fixedpoint::*;

    logic         fwd_valid;
    logic         fwd_ready;
    fixed_point_t fwd_data;
    logic         fwd_last;
    logic         grad_in_valid;
    logic         grad_in_ready;
    fixed_point_t grad_in_data;
    logic         grad_out_valid;
    logic         grad_out_ready;
    fixed_point_t grad_out_data;
    logic         grad_out_last;
    logic         overflow;

    modport master (
        output fwd_valid, fwd_data, fwd_last, grad_in_valid, grad_in_data, grad_out_ready,
        input  fwd_ready, grad_in_ready, grad_out_valid, grad_out_data, grad_out_last, overflow
    );

    modport slave (
        input  fwd_valid, fwd_data, fwd_last, grad_in_valid, grad_in_data, grad_out_ready,
        output fwd_ready, grad_in_ready, grad_out_valid, grad_out_data, grad_out_last, overflow
    );

endinterface

// File: rtl/relu_mask_buffer.sv
// DEPTH x 1-bit sign-mask store: synchronous write, combinational read.
module relu_mask_buffer #(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic             wr_bit,
    input  logic [PTR_W-1:0] rd_addr,
    output logic             rd_bit
);

    logic [DEPTH-1:0] mask;

    // Contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (wr_en)
            mask[wr_addr] <= wr_bit;
    end

    assign rd_bit = mask[rd_addr];

endmodule

// File: rtl/relu_backward.sv
// Leaky-ReLU backward pass: records z sign mask on the forward pass, then
// scales upstream gradients by LEAK wherever z was negative.
module relu_backward
    import fixedpoint::*;
#(
    parameter int           DEPTH = 64,
    parameter fixed_point_t LEAK  = 16'sh0018
) (
    input  logic           clk,
    input  logic           rst_n,
    relu_backward_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {CAPTURE, BACKWARD} state_t;

    state_t       state;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] n_cnt;
    logic         out_valid, out_last, ovf;
    fixed_point_t out_data;

    logic         fwd_fire, gin_ready, gin_fire, gout_fire;
    logic         at_depth, rd_is_last, mask_bit;
    fixed_point_t leaked;

    assign fwd_fire   = (state == CAPTURE) && bus.fwd_valid;
    assign gin_ready  = (state == BACKWARD) && (!out_valid || bus.grad_out_ready);
    assign gin_fire   = gin_ready && bus.grad_in_valid;
    assign gout_fire  = out_valid && bus.grad_out_ready;
    assign at_depth   = (wr_ptr == PTR_W'(DEPTH - 1));
    assign rd_is_last = ({1'b0, rd_ptr} == (n_cnt - CNT_W'(1)));
    assign leaked     = multiply(bus.grad_in_data, LEAK);

    relu_mask_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mask (
        .clk     (clk),
        .wr_en   (fwd_fire),
        .wr_addr (wr_ptr),
        .wr_bit  (bus.fwd_data[15]),
        .rd_addr (rd_ptr),
        .rd_bit  (mask_bit)
    );

    // Pass sequencing, pointers, output register and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            n_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (fwd_fire) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        // Either fwd_last or a full buffer ends capture.
                        if (bus.fwd_last || at_depth) begin
                            state <= BACKWARD;
                            n_cnt <= {1'b0, wr_ptr} + CNT_W'(1);
                            if (!bus.fwd_last)
                                ovf <= 1'b1;
                        end
                    end
                end
                BACKWARD: begin
                    if (gout_fire)
                        out_valid <= 1'b0;
                    if (gin_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= mask_bit ? leaked : bus.grad_in_data;
                        out_last  <= rd_is_last;
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                    end
                    // Final gradient handed off: rewind for the next pass.
                    if (gout_fire && out_last) begin
                        state  <= CAPTURE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    assign bus.fwd_ready      = (state == CAPTURE);
    assign bus.grad_in_ready  = gin_ready;
    assign bus.grad_out_valid = out_valid;
    assign bus.grad_out_data  = out_data;
    assign bus.grad_out_last  = out_last;
    assign bus.overflow       = ovf;

endmodule
